// File: rtl/psram_pkg.sv
`default_nettype none
// psram_pkg: shared width defaults, error word and FSM state encoding
// for the PSRAM port arbiter.
package psram_pkg;

  localparam int PSRAM_AW = 22;
  localparam int PSRAM_DW = 32;
  localparam logic [31:0] PSRAM_ERR_DATA = 32'hDEADBEEF;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_ISSUE   = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT    = 3'd2;
  localparam logic [ST_W-1:0] ST_RECOVER = 3'd3;
  localparam logic [ST_W-1:0] ST_ACK     = 3'd4;

  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// rr_grant: combinational round-robin pick of the first requester at or
// after ptr, wrapping modulo NREQ; returns one-hot grant and binary index.
module rr_grant
  import psram_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [IW:0] pos;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    idx = '0;
    pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      if (req[pos[IW-1:0]]) idx = pos[IW-1:0];
    end
    grant = '0;
    if (|req) grant[idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/psram_port_arbiter.sv
`default_nettype none
// psram_port_arbiter: round-robin sharing of one PSRAM burst controller among
// NREQ level-held requesters, one transaction in flight, with a hang watchdog.
module psram_port_arbiter
  import psram_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int AW      = PSRAM_AW,
  parameter int DW      = PSRAM_DW,
  parameter int TIMEOUT = 4095,
  parameter logic [DW-1:0] ERR_DATA = DW'(PSRAM_ERR_DATA)
) (
  input  logic               clk_mem,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_rd,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_d,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic [NREQ-1:0]    err,
  output logic               busy,
  output logic [AW-1:0]      mem_a,
  output logic [DW-1:0]      mem_d,
  output logic               mem_rd,
  output logic               mem_we,
  input  logic [DW-1:0]      mem_spo,
  input  logic               mem_ready
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_TO  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [ST_W-1:0] state, state_nxt;
  logic [IW-1:0]   ptr, gidx, rr_idx;
  logic [NREQ-1:0] rr_vec;
  logic            op_we;
  logic [CW-1:0]   cnt;
  logic            any_req, wait_done, timed_out;

  assign any_req   = |(req_rd | req_we);
  // The first WAIT cycle carries the pulse itself, so ready is only trusted after it.
  assign wait_done = (cnt != '0) && mem_ready;
  assign timed_out = WDOG_EN && (cnt == CNT_TO);

  rr_grant #(.NREQ(NREQ), .IW(IW)) u_rr_grant (
    .req   (req_rd | req_we),
    .ptr   (ptr),
    .grant (rr_vec),
    .idx   (rr_idx)
  );

  always_ff @(posedge clk_mem) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (any_req) state_nxt = ST_ISSUE;
      ST_ISSUE:   if (mem_ready) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (wait_done)      state_nxt = ST_ACK;
        else if (timed_out) state_nxt = ST_RECOVER;
      end
      ST_RECOVER: if (mem_ready) state_nxt = ST_ACK;
      ST_ACK:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    ack  = '0;
    if (state == ST_ACK) ack[gidx] = 1'b1;
  end

  always_ff @(posedge clk_mem) begin
    if (rst) begin
      mem_a  <= '0;
      mem_d  <= '0;
      mem_rd <= 1'b0;
      mem_we <= 1'b0;
      rdata  <= '0;
      err    <= '0;
      ptr    <= '0;
      gidx   <= '0;
      op_we  <= 1'b0;
      cnt    <= '0;
    end else begin
      mem_rd <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: if (any_req) begin
          mem_a <= req_a[rr_idx*AW +: AW];
          mem_d <= req_d[rr_idx*DW +: DW];
          // A write request wins over a simultaneous read from the same port.
          op_we <= |(req_we & rr_vec);
          gidx  <= rr_idx;
        end
        ST_ISSUE: begin
          cnt <= '0;
          if (mem_ready) begin
            mem_we <= op_we;
            mem_rd <= !op_we;
          end
        end
        ST_WAIT: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          if (wait_done) begin
            if (!op_we) rdata <= mem_spo;
          end else if (timed_out) begin
            err[gidx] <= 1'b1;
            rdata     <= ERR_DATA;
          end
        end
        ST_ACK: ptr <= IW'(wrap_inc(int'(gidx), NREQ));
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psram_port_arbiter.sv
`default_nettype none
// tb_psram_port_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic against a transaction-level memory/fairness reference.
module tb_psram_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 22;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic clk_mem = 1'b0;
  logic rst     = 1'b1;
  logic [NREQ-1:0]    req_rd = '0;
  logic [NREQ-1:0]    req_we = '0;
  logic [NREQ*AW-1:0] req_a  = '0;
  logic [NREQ*DW-1:0] req_d  = '0;
  logic [NREQ-1:0]    ack, err;
  logic [DW-1:0]      rdata, mem_d, mem_spo;
  logic [AW-1:0]      mem_a;
  logic               busy, mem_rd, mem_we, mem_ready;

  always #5 clk_mem = ~clk_mem;

  psram_port_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk_mem(clk_mem), .rst(rst), .req_rd(req_rd), .req_we(req_we),
    .req_a(req_a), .req_d(req_d), .ack(ack), .rdata(rdata), .err(err),
    .busy(busy), .mem_a(mem_a), .mem_d(mem_d), .mem_rd(mem_rd),
    .mem_we(mem_we), .mem_spo(mem_spo), .mem_ready(mem_ready)
  );

  // Controller model: busy for lat cycles after a pulse, ready masked during pulse.
  logic [31:0] cmem [256];
  int          cbusy = 0;
  int          lat   = 2;
  logic        hang  = 1'b0;
  logic [31:0] cdata = '0;

  assign mem_ready = !hang && (cbusy == 0) && !mem_rd && !mem_we;
  assign mem_spo   = (cbusy == 0) ? cdata : ~cdata;

  always @(posedge clk_mem) begin
    if (rst) cbusy <= 0;
    else if (mem_rd || mem_we) begin
      cbusy <= lat;
      if (mem_we) cmem[mem_a[7:0]] <= mem_d;
      else        cdata <= cmem[mem_a[7:0]];
    end else if (cbusy > 0) cbusy <= cbusy - 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int first_one(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic set_req(input int i, input bit rd, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rd[i] = rd;
    req_we[i] = we;
    req_a[i*AW +: AW] = a;
    req_d[i*DW +: DW] = d;
  endtask

  task automatic clr_req(input int i);
    req_rd[i] = 1'b0;
    req_we[i] = 1'b0;
  endtask

  // Runs until n acks; drop=1 releases each acked port, drop=0 keeps ports held.
  task automatic collect(input int n, input bit drop, output int ord [4],
                         output logic [DW-1:0] rv [4], output int nrd, output int nwe);
    int k = 0;
    logic [NREQ-1:0] acked;
    nrd = 0;
    nwe = 0;
    for (int j = 0; j < 4; j++) begin ord[j] = -1; rv[j] = '0; end
    for (int c = 0; c < 1000 && k < n; c++) begin
      @(negedge clk_mem);
      if (mem_rd) nrd++;
      if (mem_we) nwe++;
      acked = ack;
      if (ack != '0) begin
        check("seq ack onehot", 64'($onehot(ack)), 1);
        ord[k] = first_one(ack);
        rv[k]  = rdata;
        k++;
      end
      tick();
      if (drop) begin
        req_rd = req_rd & ~acked;
        req_we = req_we & ~acked;
      end
    end
    req_rd = '0;
    req_we = '0;
  endtask

  // Random-phase bookkeeping shared by the requester and monitor branches.
  logic [AW-1:0] cur_a    [NREQ];
  logic [DW-1:0] cur_d    [NREQ];
  bit            cur_we   [NREQ];
  bit            cur_pend [NREQ];
  int            waited   [NREQ];
  logic [DW-1:0] ref_mem  [int];
  bit            rand_done = 1'b0;
  int            acks_seen = 0;

  task automatic requester(input int i, input int n);
    int r;
    bit got;
    tick();
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      r = $urandom_range(0, 3);
      cur_a[i]    = AW'($urandom_range(0, 15));
      cur_d[i]    = $urandom;
      cur_we[i]   = (r == 1) || (r == 2);
      waited[i]   = 0;
      cur_pend[i] = 1'b1;
      set_req(i, r != 1, cur_we[i], cur_a[i], cur_d[i]);
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
        @(negedge clk_mem);
        if (ack[i]) got = 1'b1;
      end
      check($sformatf("rnd req%0d acked", i), 64'(got), 1);
      tick();
      clr_req(i);
    end
  endtask

  task automatic monitor();
    int pulses = 0;
    int g;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;
    bit pw = 1'b0;
    for (int c = 0; c < 20000 && !rand_done; c++) begin
      @(negedge clk_mem);
      if (mem_rd || mem_we) begin
        pulses++;
        pa = mem_a;
        pd = mem_d;
        pw = mem_we;
        lat = $urandom_range(1, 4);
      end
      if (ack != '0) begin
        check("rnd onehot", 64'($onehot(ack)), 1);
        g = first_one(ack);
        check("rnd one pulse", 64'(pulses), 1);
        check("rnd addr", 64'(pa), 64'(cur_a[g]));
        check("rnd op", 64'(pw), 64'(cur_we[g]));
        check("rnd fairness", 64'(waited[g] <= NREQ - 1), 1);
        if (cur_we[g]) begin
          check("rnd wdata", 64'(pd), 64'(cur_d[g]));
          ref_mem[int'(cur_a[g])] = cur_d[g];
        end else if (ref_mem.exists(int'(cur_a[g]))) begin
          check("rnd rdata", 64'(rdata), 64'(ref_mem[int'(cur_a[g])]));
        end
        for (int j = 0; j < NREQ; j++) if (j != g && cur_pend[j]) waited[j]++;
        cur_pend[g] = 1'b0;
        pulses = 0;
        acks_seen++;
      end
    end
  endtask

  typedef struct {
    int              idx;
    bit              rd;
    bit              we;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic [NREQ-1:0] exp_ack;
    bit              exp_wr;
    logic [DW-1:0]   exp_rdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int ord [4];
    logic [DW-1:0] rv [4];
    int nrd, nwe, nack;
    logic [NREQ-1:0] ack_v;
    logic [DW-1:0] rd_v, pd;
    logic [AW-1:0] pa;
    bit got;

    vecs[0] = '{0, 1'b0, 1'b1, 22'h00010,  32'h12345678, 3'b001, 1'b1, 32'h0};
    vecs[1] = '{1, 1'b1, 1'b0, 22'h00010,  32'h0,        3'b010, 1'b0, 32'h12345678};
    vecs[2] = '{2, 1'b1, 1'b1, 22'h00020,  32'hA5A5A5A5, 3'b100, 1'b1, 32'h0};
    vecs[3] = '{0, 1'b1, 1'b0, 22'h00020,  32'h0,        3'b001, 1'b0, 32'hA5A5A5A5};
    vecs[4] = '{1, 1'b0, 1'b1, 22'h3FFFFF, 32'hFFFFFFFF, 3'b010, 1'b1, 32'h0};
    vecs[5] = '{2, 1'b1, 1'b0, 22'h3FFFFF, 32'h0,        3'b100, 1'b0, 32'hFFFFFFFF};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk_mem);
    check("reset ack", 64'(ack), 0);
    check("reset busy", 64'(busy), 0);
    check("reset err", 64'(err), 0);
    check("reset mem_rd/we", 64'({mem_rd, mem_we}), 0);
    check("reset mem_a", 64'(mem_a), 0);
    check("reset mem_d", 64'(mem_d), 0);
    check("reset rdata", 64'(rdata), 0);

    for (int v = 0; v < 6; v++) begin
      tick();
      set_req(vecs[v].idx, vecs[v].rd, vecs[v].we, vecs[v].a, vecs[v].d);
      nrd = 0; nwe = 0; got = 1'b0; ack_v = '0; rd_v = '0; pa = '0; pd = '0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk_mem);
        if (mem_rd) nrd++;
        if (mem_we) nwe++;
        if (mem_rd || mem_we) begin pa = mem_a; pd = mem_d; end
        if (ack != '0) begin got = 1'b1; ack_v = ack; rd_v = rdata; end
      end
      check($sformatf("vec%0d ack", v), 64'(ack_v), 64'(vecs[v].exp_ack));
      check($sformatf("vec%0d rd pulses", v), 64'(nrd), 64'(!vecs[v].exp_wr));
      check($sformatf("vec%0d we pulses", v), 64'(nwe), 64'(vecs[v].exp_wr));
      check($sformatf("vec%0d mem_a", v), 64'(pa), 64'(vecs[v].a));
      if (vecs[v].exp_wr) check($sformatf("vec%0d mem_d", v), 64'(pd), 64'(vecs[v].d));
      else                check($sformatf("vec%0d rdata", v), 64'(rd_v), 64'(vecs[v].exp_rdata));
      tick();
      clr_req(vecs[v].idx);
      @(negedge clk_mem);
      check($sformatf("vec%0d ack width", v), 64'(ack), 0);
      check($sformatf("vec%0d idle after", v), 64'(busy), 0);
    end

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b1, AW'(32'h30 + i), 32'hC0DE0000 + i);
    collect(3, 1'b1, ord, rv, nrd, nwe);
    check("contend order0", 64'(ord[0]), 0);
    check("contend order1", 64'(ord[1]), 1);
    check("contend order2", 64'(ord[2]), 2);
    check("contend we pulses", 64'(nwe), 3);
    check("contend rd pulses", 64'(nrd), 0);

    tick();
    set_req(0, 1'b1, 1'b0, 22'h10, 32'h0);
    set_req(2, 1'b1, 1'b0, 22'h10, 32'h0);
    collect(4, 1'b0, ord, rv, nrd, nwe);
    check("fair order0", 64'(ord[0]), 0);
    check("fair order1", 64'(ord[1]), 2);
    check("fair order2", 64'(ord[2]), 0);
    check("fair order3", 64'(ord[3]), 2);
    check("fair rd pulses", 64'(nrd), 4);
    check("fair rdata", 64'(rv[3]), 32'h12345678);

    for (int i = 0; i < NREQ; i++) begin cur_pend[i] = 1'b0; waited[i] = 0; end
    fork
      begin
        fork
          requester(0, 12);
          requester(1, 12);
          requester(2, 12);
        join
        rand_done = 1'b1;
      end
      monitor();
    join
    check("rnd ack count", 64'(acks_seen), 36);
    check("rnd err clear", 64'(err), 0);

    tick();
    set_req(0, 1'b1, 1'b0, 22'h10, 32'h0);
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk_mem);
      if (mem_rd) got = 1'b1;
    end
    check("timeout pulse seen", 64'(got), 1);
    hang = 1'b1;
    nack = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk_mem);
      if (k == 15) check("timeout err early", 64'(err), 0);
      if (k == 16) check("timeout err set", 64'(err), 3'b001);
      if (ack != '0) nack++;
    end
    check("timeout ack held", 64'(nack), 0);
    hang = 1'b0;
    got = 1'b0; ack_v = '0; rd_v = '0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk_mem);
      if (ack != '0) begin got = 1'b1; ack_v = ack; rd_v = rdata; end
    end
    check("timeout ack", 64'(ack_v), 3'b001);
    check("timeout rdata", 64'(rd_v), 32'hDEADBEEF);
    check("timeout err sticky", 64'(err), 3'b001);
    tick();
    clr_req(0);

    lat = 10;
    tick();
    set_req(1, 1'b1, 1'b0, 22'h10, 32'h0);
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk_mem);
      if (mem_rd) got = 1'b1;
    end
    check("rstwait pulse seen", 64'(got), 1);
    @(negedge clk_mem);
    rst = 1'b1;
    @(negedge clk_mem);
    check("rstwait ack", 64'(ack), 0);
    check("rstwait busy", 64'(busy), 0);
    check("rstwait err", 64'(err), 0);
    check("rstwait mem_a", 64'(mem_a), 0);
    check("rstwait rdata", 64'(rdata), 0);
    rst = 1'b0;
    clr_req(1);
    lat = 2;
    tick();
    set_req(0, 1'b1, 1'b0, 22'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 22'h10, 32'h0);
    collect(2, 1'b1, ord, rv, nrd, nwe);
    check("rstwait order0", 64'(ord[0]), 0);
    check("rstwait order1", 64'(ord[1]), 1);
    check("rstwait rdata", 64'(rv[0]), 32'h12345678);
    check("rstwait rd pulses", 64'(nrd), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
